cpu_datapath: RTL and testbench

CPU_DATAPATH -- requirements
Module: cpu_datapath

---
 rtl/cpu_datapath.sv | 77 +++++++
 tb/tb_cpu_datapath.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Single-cycle datapath: 32x32 register file, ALU and 256x32 data memory with lw/sw support.
// Optional macro DP_R0_HARDWIRED_EN makes reg[0] read as zero and ignore writes.
module cpu_datapath (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  read_reg_num1,
    input  logic [4:0]  read_reg_num2,
    input  logic [4:0]  write_reg,
    input  logic [2:0]  alu_control,
    input  logic        write_enable,
    input  logic        mode,
    input  logic        lw_ctrl,
    input  logic        sw_ctrl,
    input  logic        imm_ctrl,
    input  logic [15:0] immediate,
    output logic [31:0] result
);
    logic [31:0] regs [32];
    logic [31:0] mem  [256];

    logic [31:0] rs_val, rt_val, imm_ext, op_a, op_b, alu_out, wr_data;
    logic [7:0]  addr;
    logic        mem_op, reg_we, mem_we;

`ifdef DP_R0_HARDWIRED_EN
    assign rs_val = (read_reg_num1 == 5'd0) ? 32'd0 : regs[read_reg_num1];
    assign rt_val = (read_reg_num2 == 5'd0) ? 32'd0 : regs[read_reg_num2];
    assign reg_we = write_enable && !mode && !sw_ctrl && (write_reg != 5'd0);
`else
    assign rs_val = regs[read_reg_num1];
    assign rt_val = regs[read_reg_num2];
    assign reg_we = write_enable && !mode && !sw_ctrl;
`endif

    assign mem_op  = lw_ctrl || sw_ctrl;
    assign imm_ext = {{16{immediate[15]}}, immediate};
    assign op_a    = rs_val;
    assign op_b    = (imm_ctrl || mem_op) ? imm_ext : rt_val;
    assign mem_we  = sw_ctrl && !mode;

    always_comb begin
        alu_out = op_a + op_b;
        if (!mem_op) begin
            case (alu_control)
                3'b000: alu_out = op_a + op_b;
                3'b001: alu_out = op_a - op_b;
                3'b010: alu_out = op_a & op_b;
                3'b011: alu_out = op_a | op_b;
                3'b100: alu_out = op_a ^ op_b;
                3'b101: alu_out = op_a << op_b[4:0];
                3'b110: alu_out = op_a >> op_b[4:0];
                default: alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
            endcase
        end
    end

    assign result  = alu_out;
    // Upper ALU bits are dropped so addresses wrap within the 256-word memory.
    assign addr    = alu_out[7:0];
    assign wr_data = lw_ctrl ? mem[addr] : alu_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[write_reg] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[addr] <= rt_val;
        end
    end
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed plus randomized checks of cpu_datapath against an array-based reference model.
module tb_cpu_datapath;
    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
    logic [2:0]  alu_control;
    logic        write_enable, mode, lw_ctrl, sw_ctrl, imm_ctrl;
    logic [15:0] immediate;
    logic [31:0] result;

    cpu_datapath dut (
        .clock(clock), .reset(reset),
        .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
        .write_reg(write_reg), .alu_control(alu_control),
        .write_enable(write_enable), .mode(mode), .lw_ctrl(lw_ctrl),
        .sw_ctrl(sw_ctrl), .imm_ctrl(imm_ctrl), .immediate(immediate),
        .result(result)
    );

    always #5 clock = ~clock;

    logic [31:0] m_reg [32];
    logic [31:0] m_mem [256];
    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] rd(input logic [4:0] idx);
`ifdef DP_R0_HARDWIRED_EN
        if (idx == 5'd0) return 32'd0;
`endif
        return m_reg[idx];
    endfunction

    function automatic logic [31:0] expect_result();
        logic [31:0] a, b;
        int sa, sb;
        a = rd(read_reg_num1);
        b = (imm_ctrl || lw_ctrl || sw_ctrl) ? {{16{immediate[15]}}, immediate} : rd(read_reg_num2);
        if (lw_ctrl || sw_ctrl) return a + b;
        sa = a; sb = b;
        case (alu_control)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << (b % 32);
            3'd6: return a >> (b % 32);
            default: return (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                         input logic [2:0] alu, input logic we, input logic md,
                         input logic lw, input logic sw, input logic ic, input logic [15:0] imm);
        read_reg_num1 = rs; read_reg_num2 = rt; write_reg = wr; alu_control = alu;
        write_enable = we; mode = md; lw_ctrl = lw; sw_ctrl = sw; imm_ctrl = ic; immediate = imm;
    endtask

    // Checks result before the edge, then applies the architectural effect of the edge to the model.
    task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                        input logic [2:0] alu, input logic we, input logic md,
                        input logic lw, input logic sw, input logic ic, input logic [15:0] imm);
        logic [31:0] r, ld;
        @(negedge clock);
        drive(rs, rt, wr, alu, we, md, lw, sw, ic, imm);
        #1;
        r = expect_result();
        chk(tag, result, r);
        ld = m_mem[r % 256];
        @(posedge clock);
        if (reset && !md) begin
            if (sw) m_mem[r % 256] = rd(rt);
            else if (we) begin
`ifdef DP_R0_HARDWIRED_EN
                if (wr != 5'd0) m_reg[wr] = lw ? ld : r;
`else
                m_reg[wr] = lw ? ld : r;
`endif
            end
        end
    endtask

    task automatic peek(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        @(negedge clock);
        drive(idx, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        #1;
        chk(tag, result, exp);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        reset = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        repeat (2) @(posedge clock);
        #1 chk("reset_result", result, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // immediate add, sign extension
        step("addi", 5'd0, 5'd0, 5'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);
        peek("reg1_is_5", 5'd1, 32'd5);
        step("sext", 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        chk("sext_const", result, 32'h4);

        // build DEADBEEF in reg2 using the ALU
        step("b_dead", 5'd0, 5'd0, 5'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hDEAD);
        step("b_shl", 5'd2, 5'd0, 5'd2, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd16);
        step("b_beef", 5'd0, 5'd0, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        step("b_shl2", 5'd3, 5'd0, 5'd3, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd16);
        step("b_shr", 5'd3, 5'd0, 5'd3, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd16);
        step("b_or", 5'd2, 5'd3, 5'd2, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        peek("reg2_deadbeef", 5'd2, 32'hDEADBEEF);

        // store then load
        step("sw_res", 5'd1, 5'd2, 5'd9, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3);
        chk("sw_addr", result, 32'd8);
        peek("sw_no_regwr", 5'd9, 32'd0);
        step("lw_res", 5'd1, 5'd0, 5'd4, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
        chk("lw_addr", result, 32'd8);
        peek("reg4_loaded", 5'd4, 32'hDEADBEEF);
        step("lw_sw_both", 5'd0, 5'd1, 5'd10, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd20);
        peek("both_no_regwr", 5'd10, 32'd0);

        // signed set-less-than
        step("m1", 5'd0, 5'd0, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        step("p1", 5'd0, 5'd0, 5'd6, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001);
        step("slt_a", 5'd5, 5'd6, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("slt_one", result, 32'd1);
        step("slt_b", 5'd6, 5'd5, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("slt_zero", result, 32'd0);

        // freeze
        for (int i = 0; i < 3; i++)
            step("freeze", 5'd1, 5'd2, 5'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        peek("freeze_reg1", 5'd1, 32'd5);
        step("freeze_ld", 5'd0, 5'd0, 5'd7, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5);
        peek("freeze_mem", 5'd7, 32'd0);

        // reg0 write
        step("r0_wr", 5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd7);
`ifdef DP_R0_HARDWIRED_EN
        peek("r0_read", 5'd0, 32'd0);
`else
        peek("r0_read", 5'd0, 32'd7);
`endif

        // randomized
        for (int n = 0; n < 400; n++) begin
            logic lw, sw;
            lw = ($urandom_range(0, 3) == 0);
            sw = ($urandom_range(0, 3) == 0);
            step("rand", 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0), lw, sw, 1'($urandom),
                 ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom));
        end
        for (int i = 0; i < 32; i++) peek("rand_reg", 5'(i), rd(5'(i)));

        // asynchronous reset between edges
        @(negedge clock);
        drive(5'd2, 5'd0, 5'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        #2 reset = 1'b0;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        for (int i = 0; i < 3; i++) begin
            read_reg_num1 = 5'(i * 7 + 1);
            #1 chk("async_clear", result, 32'd0);
        end
        step("in_reset", 5'd3, 5'd3, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042);
        step("in_reset_sw", 5'd3, 5'd3, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001);
        peek("reset_noreg", 5'd3, 32'd0);
        reset = 1'b1;
        step("post_ld", 5'd0, 5'd0, 5'd8, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001);
        peek("reset_nomem", 5'd8, 32'd0);
        step("post_add", 5'd0, 5'd0, 5'd9, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0123);
        peek("post_reg9", 5'd9, rd(5'd0) + 32'h123);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
